ram_controller: RTL and testbench
=================================

Name: ram_controller

Overview:
- Sequencing controller that sweeps an on-chip 256-entry byte RAM, such as the RC4 S-box memory, one address per clock.
- It drives the address, write-data and write-enable buses, and reports completion to the top-level FSM over a start/finished handshake.
- Mode 001 performs the RC4 initialisation fill, S[i] = i.

Parameters:
- ADDR_WIDTH, 8: address bus width; the sweep length is 2^ADDR_WIDTH locations.
- DATA_WIDTH, 8: write-data bus width.

Ports:
- clk, input, 1: single system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- mode, input, 3: operation select; sampled when a run is accepted.
- start, input, 1: level request from the master FSM.
- finished_bus, output, 1: completion flag, high in DONE.
- wrenbus, output, 1: RAM write enable.
- ram_in, output, DATA_WIDTH: RAM write data.
- address, output, ADDR_WIDTH: RAM address.

Behaviour:
- Reset, asynchronous, active-high: state = IDLE; address, ram_in, wrenbus, finished_bus, counter and latched mode all 0. Reset during RUN or DONE aborts immediately with no further writes.
- States: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Transition on the rising edge where start = 1 and the mode is a sweep mode (001, 010, 100).
  - That edge latches mode and clears the counter.
  - Mode changes after acceptance are ignored until the next IDLE.
- IDLE -> DONE: on the rising edge where start = 1 and the mode is any other value (000, 011, 101, 110, 111). No RAM access occurs.
- RUN:
  - address = counter, one location per cycle, ascending 0..255, 256 cycles total.
  - Mode 001: wrenbus = 1, ram_in = counter (identity fill).
  - Mode 010: wrenbus = 1, ram_in = 0 (clear fill).
  - Mode 100: wrenbus = 0, ram_in = 0 (read sweep; the downstream datapath samples the RAM output).
- RUN -> DONE: on the edge that ends the cycle with address = 255. The counter must not wrap into a 257th access.
- start is ignored during RUN; deasserting it mid-sweep does not abort or pause the sweep.
- DONE:
  - finished_bus = 1, wrenbus = 0; address holds 255 after a sweep, or 0 after an unsupported-mode request; ram_in = 0.
  - Remain in DONE while start = 1.
  - DONE -> IDLE on the edge where start = 0. finished_bus is therefore high for at least one cycle.
  - finished_bus drops in the cycle after start is seen low (4-phase handshake).
- IDLE outputs: wrenbus = 0, finished_bus = 0, address = 0, ram_in = 0.
- Back-to-back runs:
  - start held high through DONE gives no new run; the master must drop start for at least one edge to reach IDLE.
  - A start pulse low for exactly one cycle is sufficient.
- Outputs are registered, with no combinational path from start or mode to any output.
- Latency: start sampled high in IDLE at edge N gives address 0 with wrenbus = 1 after edge N. finished_bus rises after edge N+256.

Test Plan:
- Reset then mode = 001, start held high: exactly 256 consecutive cycles with wrenbus = 1, address = ram_in = 0,1,…,255. Then finished_bus = 1 and wrenbus = 0, held while start is high.
- Mode 001, start high for 170 cycles, then low: the sweep still completes all 256 writes. finished_bus is high for exactly 1 cycle, then IDLE.
- start re-raised mid-sweep, then handshake in DONE:
  - Raising start again during RUN is ignored.
  - In DONE, start held 100 cycles keeps finished_bus = 1; start low 1 cycle returns to IDLE.
  - The following start high launches a fresh sweep from address 0.
- Mode = 010: 256 writes with ram_in = 0. Mode = 100: address sweeps 0..255 with wrenbus = 0 throughout. Both end in DONE.
- Mode = 111 with start high: DONE one cycle after acceptance with no wrenbus activity. Changing mode mid-run (001 -> 010 at address 40) does not alter the data pattern.
- Assert reset at address 100 of a mode-001 sweep: all outputs go to 0 immediately, asynchronously. After release with start high, a new sweep restarts at address 0.

Source files
------------

// File: rtl/ram_controller.sv
// Sequencing controller that sweeps a 2^ADDR_WIDTH-entry RAM one address per clock
// (identity fill, clear fill or read sweep) and reports completion over a start/finished handshake.
module ram_controller #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            mode,
    input  logic                  start,
    output logic                  finished_bus,
    output logic                  wrenbus,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic [ADDR_WIDTH-1:0] address
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [2:0]            MODE_IDENT = 3'b001;
    localparam logic [2:0]            MODE_CLEAR = 3'b010;
    localparam logic [2:0]            MODE_READ  = 3'b100;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    state_t                state;
    logic [2:0]            mode_q;
    logic [ADDR_WIDTH-1:0] counter;

    function automatic logic is_sweep(input logic [2:0] m);
        return (m == MODE_IDENT) || (m == MODE_CLEAR) || (m == MODE_READ);
    endfunction

    function automatic logic write_en(input logic [2:0] m);
        return (m == MODE_IDENT) || (m == MODE_CLEAR);
    endfunction

    // Only the identity fill carries the location index as data; every other mode drives zero.
    function automatic logic [DATA_WIDTH-1:0] fill_data(input logic [2:0] m,
                                                        input logic [ADDR_WIDTH-1:0] idx);
        if (m == MODE_IDENT) begin
            return DATA_WIDTH'(idx);
        end
        return '0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mode_q       <= '0;
            counter      <= '0;
            address      <= '0;
            ram_in       <= '0;
            wrenbus      <= 1'b0;
            finished_bus <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_sweep(mode)) begin
                            state   <= RUN;
                            mode_q  <= mode;
                            counter <= '0;
                            address <= '0;
                            wrenbus <= write_en(mode);
                            ram_in  <= fill_data(mode, '0);
                        end else begin
                            state        <= DONE;
                            finished_bus <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Stop on the last location instead of wrapping into a 257th access.
                    if (counter == LAST_ADDR) begin
                        state        <= DONE;
                        finished_bus <= 1'b1;
                        wrenbus      <= 1'b0;
                        ram_in       <= '0;
                    end else begin
                        counter <= counter + ADDR_ONE;
                        address <= counter + ADDR_ONE;
                        ram_in  <= fill_data(mode_q, counter + ADDR_ONE);
                        wrenbus <= write_en(mode_q);
                    end
                end
                DONE: begin
                    wrenbus <= 1'b0;
                    ram_in  <= '0;
                    if (!start) begin
                        state        <= IDLE;
                        finished_bus <= 1'b0;
                        counter      <= '0;
                        address      <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_controller.sv
// Randomised and directed bench for ram_controller, checked every cycle against a
// queue-based model of the sweep plus a few literal expectations.
module tb_ram_controller;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    mode  = 3'd0;
    logic          start = 1'b0;
    logic          finished_bus;
    logic          wrenbus;
    logic [DW-1:0] ram_in;
    logic [AW-1:0] address;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .start        (start),
        .finished_bus (finished_bus),
        .wrenbus      (wrenbus),
        .ram_in       (ram_in),
        .address      (address)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        logic          f;
    } out_t;

    out_t q[$];
    out_t exp_o = '0;
    int   phase = 0;  // 0 waiting, 1 sweeping, 2 finished

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: an accepted sweep becomes a queue of 256 expected bus values.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            exp_o = '0;
            phase = 0;
        end else begin
            case (phase)
                0: if (start) begin
                    if (mode == 3'd1 || mode == 3'd2 || mode == 3'd4) begin
                        for (int i = 0; i < DEPTH; i++)
                            q.push_back('{a: AW'(i),
                                          d: (mode == 3'd1) ? DW'(i) : DW'(0),
                                          w: (mode != 3'd4),
                                          f: 1'b0});
                        exp_o = q.pop_front();
                        phase = 1;
                    end else begin
                        exp_o = '{a: '0, d: '0, w: 1'b0, f: 1'b1};
                        phase = 2;
                    end
                end
                1: if (q.size() > 0) begin
                    exp_o = q.pop_front();
                end else begin
                    exp_o.w = 1'b0;
                    exp_o.d = '0;
                    exp_o.f = 1'b1;
                    phase   = 2;
                end
                default: if (!start) begin
                    exp_o = '0;
                    phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("address", 32'(address), 32'(exp_o.a));
        check("ram_in", 32'(ram_in), 32'(exp_o.d));
        check("wrenbus", 32'(wrenbus), 32'(exp_o.w));
        check("finished_bus", 32'(finished_bus), 32'(exp_o.f));
    end

    task automatic run_mode(input logic [2:0] m, input int exp_cycles, input int exp_wr,
                            input int exp_addr);
        int  k    = 0;
        int  wr   = 0;
        bit  seen = 1'b0;
        mode  = m;
        start = 1'b1;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge clk);
            if (wrenbus) wr++;
            if (finished_bus) begin
                seen = 1'b1;
                k    = i;
            end
        end
        check("finish_latency", k, exp_cycles);
        check("write_count", wr, exp_wr);
        check("done_address", 32'(address), exp_addr);
        repeat (5) @(negedge clk);
        check("done_hold", 32'({finished_bus, wrenbus}), 32'b10);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  wr;
        int  fin;
        bit  found;

        repeat (3) @(negedge clk);
        check("rst_address", 32'(address), 0);
        check("rst_wrenbus", 32'(wrenbus), 0);
        check("rst_finished", 32'(finished_bus), 0);
        check("rst_ram_in", 32'(ram_in), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_mode(3'd1, 257, 256, 255);

        // Start dropped mid-sweep: sweep completes, finished pulses for one cycle.
        wr = 0; fin = 0; mode = 3'd1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wrenbus) wr++;
            if (finished_bus) fin++;
            start = (i < 170);
        end
        check("early_drop_writes", wr, 256);
        check("early_drop_finished_cycles", fin, 1);

        // Start dropped and re-raised during RUN, held in DONE, one-cycle low, fresh sweep.
        wr = 0; fin = 0; mode = 3'd1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (wrenbus) wr++;
            if (finished_bus) fin++;
            if (i == 359) check("restart_addr0", 32'({address, wrenbus}), 32'({8'd0, 1'b1}));
            if (i == 450) check("mode_change_ignored", 32'(ram_in), 91);
            if (i == 399) mode = 3'd2;
            start = !((i >= 50 && i < 120) || i == 357);
        end
        check("handshake_writes", wr, 512);
        check("handshake_finished_cycles", fin, 186);
        start = 1'b0;
        repeat (2) @(negedge clk);

        run_mode(3'd2, 257, 256, 255);
        run_mode(3'd4, 257, 0, 255);
        run_mode(3'd7, 1, 0, 0);
        run_mode(3'd0, 1, 0, 0);
        run_mode(3'd3, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 31) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) mode = 3'($urandom_range(0, 7));
        end
        start = 1'b0;
        repeat (300) @(negedge clk);

        // Asynchronous reset in the middle of an identity fill.
        mode = 3'd1; start = 1'b1; found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (address == 8'd100 && wrenbus) found = 1'b1;
        end
        check("reach_addr100", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_address", 32'(address), 0);
        check("async_rst_ram_in", 32'(ram_in), 0);
        check("async_rst_wrenbus", 32'(wrenbus), 0);
        check("async_rst_finished", 32'(finished_bus), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_restart", 32'({address, wrenbus, finished_bus}), 32'({8'd0, 1'b1, 1'b0}));
        repeat (260) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
